// File: rtl/nonce_result_scanner.sv
// rtl/nonce_result_scanner.sv - scans NUM_NONCES final-hash words against a target
// Reports first qualifying nonce, qualifying count, and minimum hash with its nonce.
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [15:0]        i_result_addr,
    input  logic [31:0]        i_target,
    output logic               o_mem_clk,
    output logic               o_mem_we,
    output logic [15:0]        o_mem_addr,
    input  logic [31:0]        i_mem_read_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_first_nonce,
    output logic [IDX_W:0]     o_match_count,
    output logic [31:0]        o_min_hash,
    output logic [IDX_W-1:0]   o_min_nonce
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(NUM_NONCES - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE_CYC = CNT_W'(NUM_NONCES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cyc;
    logic [31:0]        r_target;
    logic [15:0]        r_mem_addr;
    logic               r_busy;
    logic               r_done;
    logic               r_found;
    logic [IDX_W-1:0]   r_first_nonce;
    logic [IDX_W:0]     r_match_count;
    logic [31:0]        r_min_hash;
    logic [IDX_W-1:0]   r_min_nonce;

    logic [CNT_W-1:0]   w_cyc_next;
    logic [IDX_W-1:0]   w_idx;
    logic               w_sample;
    logic               w_hit;
    logic               w_new_min;

    // r_cyc counts FETCH edges since start; data for index i lands when r_cyc == i+1.
    assign w_cyc_next = r_cyc + CNT_ONE;
    assign w_idx      = IDX_W'(r_cyc - CNT_ONE);
    assign w_sample   = (r_cyc != '0);
    assign w_hit      = (i_mem_read_data < r_target);
    assign w_new_min  = (w_idx == '0) || (i_mem_read_data < r_min_hash);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_cyc         <= '0;
            r_target      <= '0;
            r_mem_addr    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_first_nonce <= '0;
            r_match_count <= '0;
            r_min_hash    <= 32'hFFFF_FFFF;
            r_min_nonce   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state       <= S_FETCH;
                        r_cyc         <= '0;
                        r_target      <= i_target;
                        r_mem_addr    <= i_result_addr;
                        r_busy        <= 1'b1;
                        r_found       <= 1'b0;
                        r_first_nonce <= '0;
                        r_match_count <= '0;
                        r_min_hash    <= 32'hFFFF_FFFF;
                        r_min_nonce   <= '0;
                    end
                end
                S_FETCH: begin
                    r_cyc <= w_cyc_next;
                    // Address holds once the last index is issued; extra reads are harmless.
                    if (w_cyc_next <= LAST_ISSUE) begin
                        r_mem_addr <= r_mem_addr + 16'd1;
                    end
                    if (w_sample) begin
                        if (w_hit) begin
                            r_match_count <= r_match_count + {{IDX_W{1'b0}}, 1'b1};
                            if (!r_found) begin
                                r_found       <= 1'b1;
                                r_first_nonce <= w_idx;
                            end
                        end
                        if (w_new_min) begin
                            r_min_hash  <= i_mem_read_data;
                            r_min_nonce <= w_idx;
                        end
                    end
                    if (r_cyc == LAST_SAMPLE_CYC) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!r_done) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_clk     = i_clk;
    assign o_mem_we      = 1'b0;
    assign o_mem_addr    = r_mem_addr;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_found       = r_found;
    assign o_first_nonce = r_first_nonce;
    assign o_match_count = r_match_count;
    assign o_min_hash    = r_min_hash;
    assign o_min_nonce   = r_min_nonce;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// tb/tb_nonce_result_scanner.sv - scoreboard bench for nonce_result_scanner
module tb_nonce_result_scanner;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_rd;
    logic        busy;
    logic        done;
    logic        found;
    logic [7:0]  first_nonce;
    logic [8:0]  match_count;
    logic [31:0] min_hash;
    logic [7:0]  min_nonce;

    logic [31:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        found;
        logic [7:0]  first;
        logic [8:0]  cnt;
        logic [31:0] minh;
        logic [7:0]  minn;
        int          done_cyc;
    } exp_t;

    exp_t q[$];

    nonce_result_scanner #(.NUM_NONCES(N), .IDX_W(8)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_result_addr  (result_addr),
        .i_target       (target),
        .o_mem_clk      (mem_clk),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .i_mem_read_data(mem_rd),
        .o_busy         (busy),
        .o_done         (done),
        .o_found        (found),
        .o_first_nonce  (first_nonce),
        .o_match_count  (match_count),
        .o_min_hash     (min_hash),
        .o_min_nonce    (min_nonce)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        mem_rd <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: scan the window as a list, pick first match, count matches, find minimum.
    function automatic exp_t model(input logic [15:0] a, input logic [31:0] t);
        exp_t e;
        logic [31:0] words [N];
        logic [15:0] ad;
        e.found = 1'b0;
        e.first = '0;
        e.cnt   = '0;
        for (int i = 0; i < N; i++) begin
            ad = a + 16'(i);
            words[i] = mem[ad];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (words[i] < t) begin
                e.found = 1'b1;
                e.first = 8'(i);
                e.cnt   = e.cnt + 9'd1;
            end
        end
        e.minh = words[0];
        for (int i = 1; i < N; i++)
            if (words[i] < e.minh) e.minh = words[i];
        e.minn = '0;
        for (int i = N - 1; i >= 0; i--)
            if (words[i] == e.minh) e.minn = 8'(i);
        e.done_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual 1 required 0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("latency",     32'(cyc),      32'(e.done_cyc));
                chk("found",       32'(found),    32'(e.found));
                chk("first_nonce", 32'(first_nonce), 32'(e.first));
                chk("match_count", 32'(match_count), 32'(e.cnt));
                chk("min_hash",    min_hash,      e.minh);
                chk("min_nonce",   32'(min_nonce), 32'(e.minn));
                chk("busy_at_done", 32'(busy),    32'd0);
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_done"},        32'(done),        32'd0);
        chk({tag, "_found"},       32'(found),       32'd0);
        chk({tag, "_first_nonce"}, 32'(first_nonce), 32'd0);
        chk({tag, "_match_count"}, 32'(match_count), 32'd0);
        chk({tag, "_min_hash"},    min_hash,         32'hFFFF_FFFF);
        chk({tag, "_min_nonce"},   32'(min_nonce),   32'd0);
        chk({tag, "_mem_we"},      32'(mem_we),      32'd0);
    endtask

    task automatic scan(input logic [15:0] a, input logic [31:0] t, input bit extra_starts);
        exp_t e;
        bit   seen;
        logic [15:0] exp_addr;
        @(negedge clk);
        result_addr = a;
        target      = t;
        e = model(a, t);
        e.done_cyc = cyc + N + 3;
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            if (j <= N + 1) begin
                exp_addr = a + 16'((j < N) ? j : N - 1);
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                chk("busy", 32'(busy), 32'd1);
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                start = extra_starts && (j == 2 || j == 9);
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual 0 required 1");
        end
    endtask

    initial begin
        logic [31:0] t;
        logic [15:0] a;
        rst = 1'b1;
        start = 1'b0;
        result_addr = '0;
        target = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < N; i++) mem[16'h0040 + i] = 32'h8000_0000 + 32'(i);
        scan(16'h0040, 32'h8000_0005, 1'b0);

        for (int i = 0; i < N; i++) mem[16'h0100 + i] = 32'hF000_000F - 32'(i);
        mem[16'h0100 + 11] = 32'h0000_0010;
        mem[16'h0100 + 14] = 32'h0000_0010;
        scan(16'h0100, 32'h0000_0011, 1'b0);

        scan(16'h2000, 32'h0, 1'b0);
        scan(16'hFFF8, 32'h8000_0000, 1'b0);
        scan(16'h0300, 32'hFFFF_FFFF, 1'b1);

        mem[16'h0500] = 32'hFFFF_FFFF;
        mem[16'h0501] = 32'hFFFF_FFFF;
        scan(16'h0500, 32'hFFFF_FFFF, 1'b0);

        for (int k = 0; k < 6; k++) begin
            a = 16'($urandom);
            t = mem[16'(a + 16'($urandom_range(0, N - 1)))] + 32'($urandom_range(0, 1));
            scan(a, t, 1'b0);
        end

        @(negedge clk);
        result_addr = 16'h0700;
        target = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_state("midscan_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 6) @(negedge clk);
        chk_reset_state("after_abort");

        scan(16'h0040, 32'h8000_0005, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
